// File: rtl/intersection_phase_scheduler_pkg.sv
// Shared types and constants for the intersection phase scheduler.
package intersection_pkg;

   localparam int unsigned DUR_W = 7;
   localparam int unsigned CNT_W = 5;

   typedef enum logic [1:0] {
      GREEN_A = 2'd0,
      RED_AB  = 2'd1,
      GREEN_B = 2'd2,
      RED_BA  = 2'd3
   } phase_t;

   // Green-duration bounds, normal and rush-hour.
   localparam logic [DUR_W-1:0] A_MIN_N = DUR_W'(40);
   localparam logic [DUR_W-1:0] A_MAX_N = DUR_W'(70);
   localparam logic [DUR_W-1:0] B_MIN_N = DUR_W'(50);
   localparam logic [DUR_W-1:0] B_MAX_N = DUR_W'(80);
   localparam logic [DUR_W-1:0] A_MIN_R = DUR_W'(30);
   localparam logic [DUR_W-1:0] A_MAX_R = DUR_W'(60);
   localparam logic [DUR_W-1:0] B_MIN_R = DUR_W'(40);
   localparam logic [DUR_W-1:0] B_MAX_R = DUR_W'(70);

   localparam logic [DUR_W-1:0] A_INIT = DUR_W'(40);
   localparam logic [DUR_W-1:0] B_INIT = DUR_W'(50);

endpackage

// File: rtl/intersection_phase_scheduler_green_time_calc.sv
// Next green duration from the stored duration and the road's queue count.
module green_time_calc
   import intersection_pkg::*;
#(
   parameter int unsigned STEP   = 5,
   parameter int unsigned LOW_Q  = 10,
   parameter int unsigned HIGH_Q = 19
) (
   input  logic [DUR_W-1:0] dur,
   input  logic [CNT_W-1:0] count,
   input  logic [DUR_W-1:0] min,
   input  logic [DUR_W-1:0] max,
   output logic [DUR_W-1:0] next_dur
);

   logic [DUR_W-1:0] adj;

   // Short queue lengthens the green, long queue shortens it, then clamp.
   always_comb begin
      adj = dur;
      if (32'(count) <= LOW_Q) begin
         adj = dur + DUR_W'(STEP);
      end else if (32'(count) <= HIGH_Q) begin
         adj = dur;
      end else begin
         adj = dur - DUR_W'(STEP);
      end

      next_dur = adj;
      if (adj < min) begin
         next_dur = min;
      end else if (adj > max) begin
         next_dur = max;
      end
   end

endmodule

// File: rtl/intersection_phase_scheduler.sv
// Two-road green/red phase sequencer with queue-adaptive green durations.
module intersection_phase_scheduler
   import intersection_pkg::*;
#(
   parameter int unsigned STEP   = 5,
   parameter int unsigned LOW_Q  = 10,
   parameter int unsigned HIGH_Q = 19
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic       freeze,
   input  logic       rush_hour,
   input  logic [4:0] num_cars_a,
   input  logic [4:0] num_cars_b,
   output logic       green_for_a,
   output logic       green_for_b,
   output logic [6:0] remaining_time,
   output logic [1:0] phase,
   output logic       phase_start
);

   phase_t           state, state_d;
   logic [DUR_W-1:0] dur_a, dur_b, dur_a_d, dur_b_d, rem_d;
   logic             green_a_d, green_b_d, phase_start_d;
   logic             adv;

   logic             sel_b;
   logic [DUR_W-1:0] calc_dur, calc_min, calc_max, calc_next;
   logic [CNT_W-1:0] calc_count;

   assign adv   = tick & ~freeze;
   assign phase = state;

   // RED_AB computes RoadB's next green; RED_BA (and any other state) RoadA's.
   assign sel_b      = (state == RED_AB);
   assign calc_dur   = sel_b ? dur_b : dur_a;
   assign calc_count = sel_b ? num_cars_b : num_cars_a;
   assign calc_min   = sel_b ? (rush_hour ? B_MIN_R : B_MIN_N)
                             : (rush_hour ? A_MIN_R : A_MIN_N);
   assign calc_max   = sel_b ? (rush_hour ? B_MAX_R : B_MAX_N)
                             : (rush_hour ? A_MAX_R : A_MAX_N);

   green_time_calc #(
      .STEP   (STEP),
      .LOW_Q  (LOW_Q),
      .HIGH_Q (HIGH_Q)
   ) u_calc (
      .dur      (calc_dur),
      .count    (calc_count),
      .min      (calc_min),
      .max      (calc_max),
      .next_dur (calc_next)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= GREEN_A;
         dur_a          <= A_INIT;
         dur_b          <= B_INIT;
         remaining_time <= A_INIT;
         green_for_a    <= 1'b1;
         green_for_b    <= 1'b0;
         phase_start    <= 1'b0;
      end else begin
         state          <= state_d;
         dur_a          <= dur_a_d;
         dur_b          <= dur_b_d;
         remaining_time <= rem_d;
         green_for_a    <= green_a_d;
         green_for_b    <= green_b_d;
         phase_start    <= phase_start_d;
      end
   end

   always_comb begin
      state_d = state;
      if (adv) begin
         case (state)
            GREEN_A: if (remaining_time <= DUR_W'(1)) state_d = RED_AB;
            RED_AB:  state_d = GREEN_B;
            GREEN_B: if (remaining_time <= DUR_W'(1)) state_d = RED_BA;
            RED_BA:  state_d = GREEN_A;
         endcase
      end
   end

   // Everything holds without adv, except phase_start which is a one-cycle pulse.
   always_comb begin
      dur_a_d       = dur_a;
      dur_b_d       = dur_b;
      rem_d         = remaining_time;
      green_a_d     = green_for_a;
      green_b_d     = green_for_b;
      phase_start_d = 1'b0;
      if (adv) begin
         case (state)
            GREEN_A, GREEN_B: begin
               if (remaining_time > DUR_W'(1)) begin
                  rem_d = remaining_time - DUR_W'(1);
               end else begin
                  rem_d     = '0;
                  green_a_d = 1'b0;
                  green_b_d = 1'b0;
               end
            end
            RED_AB: begin
               dur_b_d       = calc_next;
               rem_d         = calc_next;
               green_b_d     = 1'b1;
               phase_start_d = 1'b1;
            end
            RED_BA: begin
               dur_a_d       = calc_next;
               rem_d         = calc_next;
               green_a_d     = 1'b1;
               phase_start_d = 1'b1;
            end
         endcase
      end
   end

endmodule
